// File: rtl/lcd_config_sequencer_if.sv
// lcd_config_sequencer_if
//   Host-side handshake bundle between lcd_config_sequencer and the serial LCD controller.
//   master : sequencer side (drives oDATA/oSTR/status, receives iSTART/iRDY/iACK)
//   slave  : controller/host side
//   Signals: iSTART (re-run pulse), iRDY/iACK (asynchronous controller flags),
//            oDATA[15:0], oSTR, oIDX[2:0], oBUSY, oDONE, oERR,
//            ack_s (iACK after the 2-flop synchronizer, for readback observers).
interface lcd_config_sequencer_if;
  logic        iSTART;
  logic        iRDY;
  logic        iACK;
  logic [15:0] oDATA;
  logic        oSTR;
  logic [2:0]  oIDX;
  logic        oBUSY;
  logic        oDONE;
  logic        oERR;
  logic        ack_s;

  modport master (
    input  iSTART, iRDY, iACK,
    output oDATA, oSTR, oIDX, oBUSY, oDONE, oERR, ack_s
  );

  modport slave (
    output iSTART, iRDY, iACK,
    input  oDATA, oSTR, oIDX, oBUSY, oDONE, oERR, ack_s
  );
endinterface

// File: rtl/lcd_config_sequencer.sv
// lcd_config_sequencer
//   Feeds the 3-wire serial LCD controller its power-up register writes: waits PWRUP_CYC
//   after reset, then for each of 8 table words loads oDATA, raises oSTR until the
//   synchronized ready flag is seen, and holds oSTR low for a guard gap.
// Ports:
//   iCLK  - system clock, rising edge
//   iRST  - synchronous active-high reset
//   bus   - lcd_config_sequencer_if.master (iSTART, iRDY, iACK in; oDATA, oSTR, oIDX,
//           oBUSY, oDONE, oERR, ack_s out)
// Build option:
//   LCD_CFG_TIMEOUT_EN - when defined, a SEND lasting TIMEOUT_CYC cycles without ready
//   moves the block to ERR. When undefined SEND waits forever and oERR is tied low.
module lcd_config_sequencer #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned PWRUP_CYC   = CLK_FREQ / 100,
  parameter int unsigned GAP_CYC     = 6000,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  lcd_config_sequencer_if.master        bus
);

  // All cycle counts must fit the 20-bit counter.
  if (CLK_FREQ == 0 || PWRUP_CYC >= 32'd1048576 || GAP_CYC >= 32'd1048576 ||
      TIMEOUT_CYC == 0 || TIMEOUT_CYC > 32'd1048576) begin : g_param_check
    $error("lcd_config_sequencer: cycle parameter outside 20-bit counter range");
  end

  localparam logic [2:0] StPwrup = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StSend  = 3'd2;
  localparam logic [2:0] StGap   = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StErr   = 3'd5;

  // Counters start at 0 on state entry, so waiting for N means leaving when cnt == N.
  localparam logic [19:0] PwrupCnt = 20'(PWRUP_CYC);
  localparam logic [19:0] GapCnt   = 20'(GAP_CYC);
`ifdef LCD_CFG_TIMEOUT_EN
  // oSTR is high from the SEND entry edge, so leaving at TIMEOUT_CYC-1 gives
  // exactly TIMEOUT_CYC high cycles.
  localparam logic [19:0] TimeoutCnt = 20'(TIMEOUT_CYC - 1);
`endif

  function automatic logic [15:0] cfg_word(input logic [2:0] idx);
    logic [15:0] w;
    case (idx)
      3'd0:    w = 16'h0807;
      3'd1:    w = 16'h0C5F;
      3'd2:    w = 16'h1017;
      3'd3:    w = 16'h1420;
      3'd4:    w = 16'h1820;
      3'd5:    w = 16'h1C20;
      3'd6:    w = 16'h2020;
      default: w = 16'h2420;
    endcase
    return w;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic        str_q, str_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rdy_meta_q, rdy_s_q;
  logic        ack_meta_q, ack_s_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 20'd1;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      StPwrup: begin
        if (cnt_q == PwrupCnt) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        data_d  = cfg_word(idx_q);
        state_d = StSend;
        cnt_d   = '0;
      end
      StSend: begin
        // Ready is checked first so it wins over a coincident timeout.
        if (rdy_s_q) begin
          state_d = StGap;
          cnt_d   = '0;
        end
`ifdef LCD_CFG_TIMEOUT_EN
        else if (cnt_q == TimeoutCnt) begin
          state_d = StErr;
          cnt_d   = '0;
        end
`else
        else begin
          cnt_d = cnt_q;
        end
`endif
      end
      StGap: begin
        if (cnt_q == GapCnt) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StLoad;
          end
        end
      end
      StDone, StErr: begin
        cnt_d = cnt_q;
        if (bus.iSTART) begin
          idx_d   = '0;
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StPwrup;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with state entry.
    str_d  = (state_d == StSend);
    busy_d = !((state_d == StDone) || (state_d == StErr));
    done_d = (state_d == StDone);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= StPwrup;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      str_q      <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      str_q      <= str_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdy_meta_q <= bus.iRDY;
      rdy_s_q    <= rdy_meta_q;
      ack_meta_q <= bus.iACK;
      ack_s_q    <= ack_meta_q;
    end
  end

`ifdef LCD_CFG_TIMEOUT_EN
  logic err_q, err_d;

  always_comb begin
    err_d = (state_d == StErr);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.oERR = err_q;
`else
  assign bus.oERR = 1'b0;
`endif

  assign bus.oDATA = data_q;
  assign bus.oSTR  = str_q;
  assign bus.oIDX  = idx_q;
  assign bus.oBUSY = busy_q;
  assign bus.oDONE = done_q;
  assign bus.ack_s = ack_s_q;

endmodule

// File: tb/tb_lcd_config_sequencer.sv
// Self-checking bench for lcd_config_sequencer. A timeline model (power-up wait, ready
// latency, gap length, done/start rules) predicts every output each cycle; a few literal
// expectations pin that model to the documented timing.
module tb_lcd_config_sequencer;
  localparam int unsigned Pwrup = 20;
  localparam int unsigned Gap   = 10;
  localparam int unsigned Tmo   = 50;

  localparam int PhWait = 0;
  localparam int PhHigh = 1;
  localparam int PhGap  = 2;
  localparam int PhDone = 3;
  localparam int PhErr  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lcd_config_sequencer_if bus ();

  lcd_config_sequencer #(
    .CLK_FREQ   (50000000),
    .PWRUP_CYC  (Pwrup),
    .GAP_CYC    (Gap),
    .TIMEOUT_CYC(Tmo)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  logic [15:0] tbl [8] = '{16'h0807, 16'h0C5F, 16'h1017, 16'h1420,
                           16'h1820, 16'h1C20, 16'h2020, 16'h2420};

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_str, m_busy, m_done, m_err, m_ack;
  logic [15:0] m_data;
  logic [2:0]  m_idx;
  int          phase, timer, hi_n;
  logic        rp0, rp1, ap0, rdy_del;
  bit          chk_en = 0;

  task automatic model_rise();
    m_str  = 1'b1;
    m_data = tbl[m_idx];
    phase  = PhHigh;
    hi_n   = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      // iRDY is acted on two edges after it is sampled; ack_s shows iACK one edge late.
      rdy_del = rp1;
      rp1     = rp0;
      rp0     = bus.iRDY;
      m_ack   = ap0;
      ap0     = bus.iACK;
      if (rst) begin
        rp0 = 0; rp1 = 0; ap0 = 0; m_ack = 0;
        m_str = 0; m_data = '0; m_idx = '0; m_busy = 1; m_done = 0; m_err = 0;
        phase = PhWait;
        timer = Pwrup + 2;
      end else begin
        case (phase)
          PhWait: begin
            timer--;
            if (timer == 0) model_rise();
          end
          PhHigh: begin
            if (rdy_del) begin
              m_str = 0;
              phase = PhGap;
              timer = Gap + 2;
            end
`ifdef LCD_CFG_TIMEOUT_EN
            else begin
              hi_n++;
              if (hi_n == Tmo) begin
                m_str  = 0;
                m_err  = 1;
                m_busy = 0;
                phase  = PhErr;
              end
            end
`endif
          end
          PhGap: begin
            timer--;
            if (timer == 1) begin
              if (m_idx == 3'd7) begin
                m_done = 1;
                m_busy = 0;
                phase  = PhDone;
              end else begin
                m_idx = m_idx + 3'd1;
              end
            end else if (timer == 0) begin
              model_rise();
            end
          end
          default: begin
            if (bus.iSTART) begin
              m_err  = 0;
              m_done = 0;
              m_busy = 1;
              m_idx  = '0;
              phase  = PhWait;
              timer  = 1;
            end
          end
        endcase
      end
      chk_en = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cmp_oSTR", bus.oSTR, m_str);
        check("cmp_oDATA", bus.oDATA, m_data);
        check("cmp_oIDX", bus.oIDX, m_idx);
        check("cmp_oBUSY", bus.oBUSY, m_busy);
        check("cmp_oDONE", bus.oDONE, m_done);
        check("cmp_oERR", bus.oERR, m_err);
        check("cmp_ack_s", bus.ack_s, m_ack);
      end
    end
  end

  // ---------------- controller stand-in: iRDY/iACK ----------------
  bit       rand_rdy = 0;
  bit       stall_en = 0;
  int       rdy_delay = 30;
  int       hi_cnt = 0;

  initial begin
    bus.iRDY = 1'b0;
    bus.iACK = 1'b0;
    forever begin
      @(negedge clk);
      bus.iACK = 1'($urandom_range(0, 1));
      if (bus.oSTR) begin
        hi_cnt++;
        if (hi_cnt == rdy_delay && !(stall_en && bus.oIDX == 3'd2)) bus.iRDY = 1'b1;
      end else begin
        hi_cnt    = 0;
        bus.iRDY  = 1'b0;
        rdy_delay = rand_rdy ? int'($urandom_range(1, 40)) : 30;
      end
    end
  end

  // ---------------- word / gap recorder ----------------
  logic [15:0] words[$];
  int          gaps[$];
  logic        prev_str = 1'b0;
  int          low_n = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.oSTR && !prev_str) begin
        words.push_back(bus.oDATA);
        gaps.push_back(low_n);
      end
      low_n    = bus.oSTR ? 0 : low_n + 1;
      prev_str = bus.oSTR;
    end
  end

  task automatic check_run(input string name);
    check($sformatf("%s_word_count", name), words.size(), 8);
    for (int i = 0; i < 8 && i < words.size(); i++) begin
      check($sformatf("%s_word%0d", name, i), words[i], tbl[i]);
      if (i > 0) check($sformatf("%s_gap%0d", name, i), gaps[i], 12);
    end
  endtask

  task automatic measure_rise(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.oSTR && n < 100);
    check(name, n, exp_n);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.oDONE && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.oDONE, 1);
  endtask

  // ---------------- directed + randomized flow ----------------
  initial begin
    int  n;
    bit  found;
    bus.iSTART = 1'b0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_oSTR", bus.oSTR, 0);
    check("rst_oDATA", bus.oDATA, 16'h0000);
    check("rst_oIDX", bus.oIDX, 0);
    check("rst_oBUSY", bus.oBUSY, 1);
    check("rst_oDONE", bus.oDONE, 0);
    check("rst_oERR", bus.oERR, 0);

    // Run 1: fixed ready latency, full table from reset.
    words.delete();
    gaps.delete();
    rst = 1'b0;
    measure_rise("first_rise_cycle", 22);
    check("first_word", bus.oDATA, 16'h0807);
    repeat (5) @(negedge clk);
    bus.iSTART = 1'b1;
    @(negedge clk);
    bus.iSTART = 1'b0;
    check("start_in_send_str", bus.oSTR, 1);
    check("start_in_send_idx", bus.oIDX, 0);
    wait_done("run1_done", 2000);
    @(negedge clk);
    check_run("run1");
    check("run1_idx", bus.oIDX, 7);
    check("run1_busy", bus.oBUSY, 0);

    // Run 2: restart from DONE with random ready latency and iSTART noise.
    rand_rdy = 1;
    words.delete();
    gaps.delete();
    bus.iSTART = 1'b1;
    @(negedge clk);
    bus.iSTART = 1'b0;
    n = 1;
    while (!bus.oSTR && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("start_to_str", n, 2);
    check("start_word", bus.oDATA, 16'h0807);
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.oIDX == 3'd3 && bus.oSTR) begin
        found = 1;
        break;
      end
      bus.iSTART = ($urandom_range(0, 15) == 0);
    end
    bus.iSTART = 1'b0;
    check("reach_idx3_send", found, 1);

    // Reset mid-transfer at idx 3.
    rst = 1'b1;
    @(negedge clk);
    check("midrst_oSTR", bus.oSTR, 0);
    check("midrst_oDATA", bus.oDATA, 16'h0000);
    check("midrst_oIDX", bus.oIDX, 0);
    check("midrst_oBUSY", bus.oBUSY, 1);
    words.delete();
    gaps.delete();
    rst = 1'b0;
    measure_rise("midrst_restart_cycle", 22);
    check("midrst_first_word", bus.oDATA, 16'h0807);
    wait_done("run2_done", 4000);
    @(negedge clk);
    check_run("run2");

`ifdef LCD_CFG_TIMEOUT_EN
    // Run 3: controller never answers at idx 2.
    stall_en = 1;
    bus.iSTART = 1'b1;
    @(negedge clk);
    bus.iSTART = 1'b0;
    n = 0;
    while (!(bus.oSTR && bus.oIDX == 3'd2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_reach_idx2", bus.oSTR && bus.oIDX == 3'd2, 1);
    n = 0;
    while (bus.oSTR && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("tmo_high_cycles", n, 50);
    check("tmo_oERR", bus.oERR, 1);
    check("tmo_oSTR", bus.oSTR, 0);
    check("tmo_oIDX", bus.oIDX, 2);
    check("tmo_oBUSY", bus.oBUSY, 0);
    stall_en = 0;
    words.delete();
    gaps.delete();
    bus.iSTART = 1'b1;
    @(negedge clk);
    bus.iSTART = 1'b0;
    check("err_start_oERR", bus.oERR, 0);
    check("err_start_oIDX", bus.oIDX, 0);
    check("err_start_oBUSY", bus.oBUSY, 1);
    wait_done("run3_done", 4000);
    @(negedge clk);
    check_run("run3");
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_config_sequencer.md
# lcd_config_sequencer

Host-side sequencer that feeds the 3-wire serial LCD controller with its power-up register writes. After reset it waits a power-up delay, then walks a fixed 8-entry register table. For each word it:
- drives the controller's 16-bit data word and strobe;
- waits for the controller's ready flag;
- releases the strobe for a guard gap before the next word.

It sits directly upstream of the serial controller, in the same 50 MHz system clock domain as that controller's host side.

## Interface
- CLK_FREQ, 50000000 – system clock frequency in Hz; documentation only.
- PWRUP_CYC, 500000 – iCLK cycles between reset release and the first transfer (10 ms).
- GAP_CYC, 6000 – iCLK cycles with oSTR low between transfers; must exceed one serial-clock period of the controller.
- TIMEOUT_CYC, 200000 – maximum iCLK cycles oSTR may stay high waiting for ready; used only with the macro below.
- iCLK  in  1  system clock; all logic on its rising edge.
- iRST  in  1  synchronous, active-high reset.
- iSTART  in  1  one-cycle pulse; re-runs the table from the DONE or ERR state.
- iRDY  in  1  ready flag from the serial controller; treated as asynchronous.
- iACK  in  1  ack/readback bit from the serial controller; treated as asynchronous.
- oDATA  out  16  word presented to the controller.
- oSTR  out  1  transfer strobe to the controller; held high for the whole transfer.
- oIDX  out  3  index of the current table entry.
- oBUSY  out  1  high from reset release until DONE or ERR is reached.
- oDONE  out  1  high while in DONE.
- oERR  out  1  high while in ERR.

## Operation
- Table contents, index 0..7: 16'h0807, 16'h0C5F, 16'h1017, 16'h1420, 16'h1820, 16'h1C20, 16'h2020, 16'h2420.
- iRDY and iACK pass through a 2-flop synchronizer to give rdy_s and ack_s.
- States:
  - PWRUP: count PWRUP_CYC, then go to LOAD.
  - LOAD: oDATA <= table[idx], go to SEND.
  - SEND: oSTR=1; on rdy_s=1 go to GAP and clear the counter.
  - GAP: oSTR=0; count GAP_CYC. At the end, if idx==7 go to DONE; otherwise idx++ and go to LOAD.
  - DONE: hold all outputs.
  - ERR: hold all outputs.
- iSTART is honoured only in DONE or ERR. It sets idx=0, clears oERR, and goes to LOAD with no power-up wait. iSTART in any other state is ignored.
- Reset values: state=PWRUP, idx=0, oDATA=16'h0000, oSTR=0, oIDX=0, oBUSY=1, oDONE=0, oERR=0, counters=0.
- Reset asserted mid-transfer drops oSTR on the next edge; this forces the controller back to idle. After reset the full sequence restarts, including the power-up wait.
- Counters are 20-bit and saturate-free: they are cleared on every state entry and compared with ==.
- oDATA changes only in LOAD, so it is stable for the whole time oSTR is high.

## Timing
- Reset release to first oSTR rise: PWRUP_CYC + 2 cycles (PWRUP terminal count, LOAD, then SEND).
- iRDY rise to oSTR fall: 3 cycles (2 synchronizer stages plus the registered output).
- oSTR low time between words: GAP_CYC + 2 cycles (GAP count, LOAD, SEND entry).
- oDONE rises 1 cycle after the last GAP count completes. oBUSY falls on the same edge.
- iSTART sampled in DONE: oSTR rises 2 cycles later.

## Configuration
- Macro LCD_CFG_TIMEOUT_EN.
- When defined:
  - A counter runs while in SEND.
  - Reaching TIMEOUT_CYC without rdy_s moves the block to ERR: oSTR=0, oERR=1, oBUSY=0, oIDX frozen at the failing entry.
  - If rdy_s and the timeout occur on the same cycle, rdy_s wins.
- When undefined:
  - SEND waits indefinitely for ready.
  - oERR is tied to 0 and the ERR state is unreachable.

## Test plan
- Bench settings: PWRUP_CYC=20, GAP_CYC=10, TIMEOUT_CYC=50. The iRDY model rises 30 cycles after oSTR rises and falls when oSTR falls.
- Reset released -> oSTR first rises at cycle 22 with oDATA=16'h0807. Eight strobes follow with the table words in order, then oDONE=1, oBUSY=0, oIDX=7.
- oSTR gap check -> between consecutive words, oSTR stays low for exactly 12 cycles. oDATA never changes while oSTR=1.
- iRST pulsed while oSTR=1 at idx=3 -> oSTR=0 on the next edge and all outputs return to their reset values. The sequence then restarts at 16'h0807 after 22 cycles.
- iSTART pulsed in DONE -> oSTR rises 2 cycles later with 16'h0807, with no power-up wait. The same pulse sent during SEND is ignored.
- With LCD_CFG_TIMEOUT_EN defined and iRDY held 0 at idx=2 -> after 50 cycles: oERR=1, oSTR=0, oIDX=2. A following iSTART clears oERR and restarts from idx 0.
